// File: rtl/fsb_arb_pkg.sv
// Shared types and helpers for the FSB burst arbiter.
package fsb_arb_pkg;

  localparam int FSB_WIDTH_DEFAULT = 80;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // A burst length of 0 still moves one packet; anything above max_len is capped.
  function automatic int clamp_burst(input int len, input int max_len);
    if (len <= 0) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/fsb_rr_pick.sv
// Combinational round-robin picker: first requester after last_i, with wrap.
module fsb_rr_pick
  import fsb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_i,
  output logic               found_o,
  output logic [IW-1:0]      idx_o
);

  logic [IW-1:0] w_cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IW'((int'(last_i) + k) % NUM_REQ);
      if (!found_o && req_i[w_cand]) begin
        found_o = 1'b1;
        idx_o   = w_cand;
      end
    end
  end

endmodule

// File: rtl/fsb_burst_arbiter.sv
// Round-robin burst arbiter sharing one FSB valid/ready channel among NUM_REQ requesters.
// Define FSB_BURST_ARBITER_STATS_EN to build the per-requester saturating packet counters.
module fsb_burst_arbiter
  import fsb_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int FSB_WIDTH = FSB_WIDTH_DEFAULT,
  parameter int BURST_MAX = 4,
  parameter int CNT_WIDTH = 32,
  localparam int IW = $clog2(NUM_REQ),
  localparam int BW = $clog2(BURST_MAX + 1)
) (
  input  logic                           clk,
  input  logic                           pipe_rst_n,
  input  logic [NUM_REQ-1:0]             req_v_i,
  input  logic [NUM_REQ*FSB_WIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]             req_yumi_o,
  output logic                           out_v_o,
  output logic [FSB_WIDTH-1:0]           out_data_o,
  output logic [IW-1:0]                  out_src_o,
  input  logic                           out_ready_i,
  input  logic [BW-1:0]                  burst_len_i,
  input  logic                           enable_i,
  output logic                           idle_o,
  output logic [NUM_REQ*CNT_WIDTH-1:0]   pkt_cnt_o
);

  arb_state_e             r_state;
  logic [IW-1:0]          r_grant;
  logic [IW-1:0]          r_last;
  logic [BW-1:0]          r_burst_cnt;
  logic                   r_out_v;
  logic [FSB_WIDTH-1:0]   r_out_data;
  logic [IW-1:0]          r_out_src;

  logic                   w_found;
  logic [IW-1:0]          w_win;
  logic                   w_yumi;
  logic [NUM_REQ-1:0]     w_yumi_vec;
  logic [FSB_WIDTH-1:0]   w_req_data [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_req_data[g] = req_data_i[g*FSB_WIDTH +: FSB_WIDTH];
  end

  fsb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i   (req_v_i),
    .last_i  (r_last),
    .found_o (w_found),
    .idx_o   (w_win)
  );

  // A packet is consumed only while granted and the output slot is free or draining.
  assign w_yumi = (r_state == BURST) & req_v_i[r_grant] & (~r_out_v | out_ready_i);

  always_comb begin
    w_yumi_vec          = '0;
    w_yumi_vec[r_grant] = w_yumi;
  end

  always_ff @(posedge clk or negedge pipe_rst_n) begin
    if (!pipe_rst_n) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_last      <= IW'(NUM_REQ - 1);
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable_i && w_found) begin
            r_grant     <= w_win;
            r_last      <= w_win;
            r_burst_cnt <= BW'(clamp_burst(int'(burst_len_i), BURST_MAX));
            r_state     <= BURST;
          end
        end
        BURST: begin
          if (w_yumi && (r_burst_cnt == BW'(1))) begin
            r_state <= IDLE;
          end else if (!req_v_i[r_grant]) begin
            r_state <= IDLE;
          end else if (w_yumi) begin
            r_burst_cnt <= r_burst_cnt - BW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output slot: a new load wins over a drain in the same cycle.
  always_ff @(posedge clk or negedge pipe_rst_n) begin
    if (!pipe_rst_n) begin
      r_out_v    <= 1'b0;
      r_out_data <= '0;
      r_out_src  <= '0;
    end else if (w_yumi) begin
      r_out_v    <= 1'b1;
      r_out_data <= w_req_data[r_grant];
      r_out_src  <= r_grant;
    end else if (out_ready_i) begin
      r_out_v    <= 1'b0;
    end
  end

  assign req_yumi_o = w_yumi_vec;
  assign out_v_o    = r_out_v;
  assign out_data_o = r_out_data;
  assign out_src_o  = r_out_src;
  assign idle_o     = (r_state == IDLE) & ~r_out_v;

`ifdef FSB_BURST_ARBITER_STATS_EN
  logic [CNT_WIDTH-1:0] r_cnt [NUM_REQ];

  always_ff @(posedge clk or negedge pipe_rst_n) begin
    if (!pipe_rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_yumi_vec[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign pkt_cnt_o[g*CNT_WIDTH +: CNT_WIDTH] = r_cnt[g];
  end
`else
  assign pkt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fsb_burst_arbiter.sv
// Scoreboard bench for fsb_burst_arbiter with a transaction-level arbitration model.
module tb_fsb_burst_arbiter;

  localparam int NR = 2;
  localparam int FW = 80;
  localparam int BM = 4;
  localparam int CW = 32;
  localparam int BW = 3;

  logic              clk = 1'b0;
  logic              pipe_rst_n;
  logic [NR-1:0]     req_v_i;
  logic [NR*FW-1:0]  req_data_i;
  logic [NR-1:0]     req_yumi_o;
  logic              out_v_o;
  logic [FW-1:0]     out_data_o;
  logic              out_src_o;
  logic              out_ready_i;
  logic [BW-1:0]     burst_len_i;
  logic              enable_i;
  logic              idle_o;
  logic [NR*CW-1:0]  pkt_cnt_o;

  always #5 clk = ~clk;

  fsb_burst_arbiter #(.NUM_REQ(NR), .FSB_WIDTH(FW), .BURST_MAX(BM), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .pipe_rst_n  (pipe_rst_n),
    .req_v_i     (req_v_i),
    .req_data_i  (req_data_i),
    .req_yumi_o  (req_yumi_o),
    .out_v_o     (out_v_o),
    .out_data_o  (out_data_o),
    .out_src_o   (out_src_o),
    .out_ready_i (out_ready_i),
    .burst_len_i (burst_len_i),
    .enable_i    (enable_i),
    .idle_o      (idle_o),
    .pkt_cnt_o   (pkt_cnt_o)
  );

  typedef struct {
    logic [FW-1:0] data;
    int            src;
  } exp_t;

  logic [FW-1:0] txq [NR][$];
  exp_t          sbq [$];
  int            xfer_cyc [$];
  int            xfer_src [$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
  int            cyc = 0;
  int            m_last = NR - 1;
  int            exp_cnt [NR];
  logic [NR-1:0] yumi_pend;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Requesters: each drives the head of its queue and pops it after a consumed cycle.
  initial begin
    yumi_pend   = '0;
    req_v_i     = '0;
    req_data_i  = '0;
    out_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++)
        if (yumi_pend[i] && txq[i].size() > 0) void'(txq[i].pop_front());
      for (int i = 0; i < NR; i++) begin
        req_v_i[i] = (txq[i].size() > 0);
        req_data_i[i*FW +: FW] = (txq[i].size() > 0) ? txq[i][0] : '0;
      end
      case (ready_mode)
        0:       out_ready_i = 1'b1;
        1:       out_ready_i = ($urandom_range(0, 9) < 7);
        default: out_ready_i = 1'b0;
      endcase
      #1;
      yumi_pend = req_yumi_o;
    end
  end

  // Monitor: protocol checks every cycle, scoreboard pop on every output transfer.
  initial begin
    logic          prev_hold;
    logic [FW-1:0] prev_data;
    logic          prev_src;
    exp_t          e;
    prev_hold = 1'b0;
    prev_data = '0;
    prev_src  = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!pipe_rst_n) begin
        prev_hold = 1'b0;
      end else begin
        check("yumi_onehot", 128'($countones(req_yumi_o) <= 1), 128'(1));
        check("yumi_without_valid", 128'(req_yumi_o & ~req_v_i), 128'(0));
        if (out_v_o && !out_ready_i) check("yumi_during_stall", 128'(req_yumi_o), 128'(0));
        if (prev_hold) begin
          check("hold_valid", 128'(out_v_o), 128'(1));
          check("hold_data", 128'(out_data_o), 128'(prev_data));
          check("hold_src", 128'(out_src_o), 128'(prev_src));
        end
        prev_hold = out_v_o && !out_ready_i;
        prev_data = out_data_o;
        prev_src  = out_src_o;
        if (out_v_o && out_ready_i) begin
          xfer_cyc.push_back(cyc);
          xfer_src.push_back(int'(out_src_o));
          if (sbq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output actual=%0h required=none", out_data_o);
          end else begin
            e = sbq.pop_front();
            check("out_data", 128'(out_data_o), 128'(e.data));
            check("out_src", 128'(out_src_o), 128'(e.src));
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  function automatic int clampm(input int l);
    if (l == 0) return 1;
    if (l > BM) return BM;
    return l;
  endfunction

  // Load n0/n1 packets at once and predict the full delivery order: each turn the next
  // non-empty requester after the previous winner sends min(burst, remaining) packets.
  task automatic load2(input int n0, input int n1, input int blen);
    int            rem [NR];
    logic [FW-1:0] pk [NR][$];
    logic [95:0]   r96;
    exp_t          e;
    int            w, c, t;
    rem[0] = n0;
    rem[1] = n1;
    burst_len_i = blen[BW-1:0];
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < rem[i]; j++) begin
        r96 = {$urandom(), $urandom(), $urandom()};
        pk[i].push_back(r96[FW-1:0]);
        txq[i].push_back(r96[FW-1:0]);
      end
    while (rem[0] + rem[1] > 0) begin
      w = -1;
      for (int k = 1; k <= NR; k++) begin
        c = (m_last + k) % NR;
        if (w < 0 && rem[c] > 0) w = c;
      end
      t = (clampm(blen) < rem[w]) ? clampm(blen) : rem[w];
      for (int j = 0; j < t; j++) begin
        e.data = pk[w].pop_front();
        e.src  = w;
        sbq.push_back(e);
      end
      rem[w]     -= t;
      exp_cnt[w] += t;
      m_last      = w;
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (!(sbq.size() == 0 && txq[0].size() == 0 && txq[1].size() == 0 && idle_o) && n < 1500) begin
      tick();
      n++;
    end
    if (n >= 1500) fail_now({nm, "_drain"});
    else check({nm, "_idle"}, 128'(idle_o), 128'(1));
  endtask

  task automatic check_gaps(input string nm, input int base, input int eg [$]);
    if (xfer_cyc.size() < base + eg.size() + 1) begin
      fail_now({nm, "_gap_count"});
    end else begin
      for (int k = 0; k < eg.size(); k++)
        check($sformatf("%s_gap%0d", nm, k), 128'(xfer_cyc[base+k+1] - xfer_cyc[base+k]), 128'(eg[k]));
    end
  endtask

  task automatic check_counts(input string nm);
`ifdef FSB_BURST_ARBITER_STATS_EN
    for (int i = 0; i < NR; i++)
      check($sformatf("%s_cnt%0d", nm, i), 128'(pkt_cnt_o[i*CW +: CW]), 128'(exp_cnt[i]));
`else
    check({nm, "_cnt_tied"}, 128'(pkt_cnt_o), 128'(0));
`endif
  endtask

  initial begin
    int base, n, sz;
    int eg [$];
    int seq_b [6];
    seq_b = '{0, 0, 1, 1, 0, 0};
    for (int i = 0; i < NR; i++) exp_cnt[i] = 0;
    pipe_rst_n  = 1'b0;
    enable_i    = 1'b1;
    burst_len_i = 3'd4;
    ready_mode  = 0;
    repeat (3) tick();
    check("rst_out_v", 128'(out_v_o), 128'(0));
    check("rst_idle", 128'(idle_o), 128'(1));
    check("rst_yumi", 128'(req_yumi_o), 128'(0));
    check("rst_data", 128'(out_data_o), 128'(0));
    check("rst_src", 128'(out_src_o), 128'(0));
    check_counts("rst");
    pipe_rst_n = 1'b1;
    tick();

    // Both requesters always valid, burst of 2.
    base = xfer_src.size();
    load2(4, 4, 2);
    drain("rr");
    if (xfer_src.size() < base + 6) fail_now("rr_len");
    else for (int k = 0; k < 6; k++)
      check($sformatf("rr_src%0d", k), 128'(xfer_src[base+k]), 128'(seq_b[k]));

    // Single requester, 6 packets, burst 4: one bubble between bursts.
    base = xfer_cyc.size();
    load2(6, 0, 4);
    drain("single");
    eg = {1, 1, 1, 2, 1};
    check_gaps("single", base, eg);

    // Burst length 0 behaves as 1, 7 clamps to 4.
    base = xfer_cyc.size();
    load2(3, 0, 0);
    drain("blen0");
    eg = {2, 2};
    check_gaps("blen0", base, eg);
    base = xfer_cyc.size();
    load2(6, 0, 7);
    drain("blen7");
    eg = {1, 1, 1, 2, 1};
    check_gaps("blen7", base, eg);

    // enable_i dropped mid-burst: current burst completes, no new grant.
    base = xfer_src.size();
    load2(8, 0, 4);
    n = 0;
    while (xfer_src.size() <= base && n < 50) begin tick(); n++; end
    if (n >= 50) fail_now("en_first");
    enable_i = 1'b0;
    repeat (30) tick();
    check("en_count", 128'(xfer_src.size() - base), 128'(4));
    check("en_idle", 128'(idle_o), 128'(1));
    check("en_left", 128'(txq[0].size()), 128'(4));
    enable_i = 1'b1;
    drain("en");

    // Backpressure mid-burst for 5 cycles.
    base = xfer_src.size();
    load2(6, 0, 4);
    n = 0;
    while (xfer_src.size() < base + 2 && n < 50) begin tick(); n++; end
    if (n >= 50) fail_now("bp_start");
    ready_mode = 2;
    tick();
    sz = txq[0].size();
    repeat (4) tick();
    check("bp_out_v", 128'(out_v_o), 128'(1));
    check("bp_no_consume", 128'(txq[0].size()), 128'(sz));
    ready_mode = 0;
    drain("bp");
    check_counts("mid");

    // Reset while a packet sits in the output register.
    ready_mode = 2;
    load2(3, 0, 4);
    n = 0;
    while (!out_v_o && n < 20) begin tick(); n++; end
    if (n >= 20) fail_now("rst_fill");
    pipe_rst_n = 1'b0;
    #1;
    check("async_rst_out_v", 128'(out_v_o), 128'(0));
    check("async_rst_idle", 128'(idle_o), 128'(1));
    sbq.delete();
    for (int i = 0; i < NR; i++) begin
      txq[i].delete();
      exp_cnt[i] = 0;
    end
    yumi_pend = '0;
    m_last = NR - 1;
    check_counts("async_rst");
    repeat (2) tick();
    pipe_rst_n = 1'b1;
    ready_mode = 0;
    tick();
    base = xfer_src.size();
    load2(2, 2, 2);
    drain("post_rst");
    if (xfer_src.size() <= base) fail_now("post_rst_first");
    else check("post_rst_first_src", 128'(xfer_src[base]), 128'(0));

    // Randomised traffic, burst lengths and backpressure.
    for (int r = 0; r < 14; r++) begin
      ready_mode = (r % 3 == 2) ? 0 : 1;
      load2($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      drain($sformatf("rand%0d", r));
    end
    ready_mode = 0;
    tick();
    check_counts("final");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
